bmp_frame_writer: RTL
=====================

# bmp_frame_writer

Downstream sink for the two-pixels-per-clock image reader stream. It consumes the reader's V_sync/H_sync-qualified RGB pixel pairs and rebuilds a complete 24-bit BMP image in a 48-bit-wide byte-addressed write port. It first emits a 54-byte BMP header, then the pixel data with rows flipped back to file order. It feeds the frame memory or file-dump model in the processing chain and signals frame completion.

## Interface
Parameters:
- WIDTH, 768: image width in pixels; must be even.
- HEIGHT, 512: image height in pixels.
- ADDR_WIDTH, 21: byte-address width; must satisfy 2^ADDR_WIDTH > 54+WIDTH*HEIGHT*3.

Ports (clock and reset first):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- V_sync  in  1  frame-active level from the reader.
- H_sync  in  1  beat valid: one pixel pair per cycle while high.
- red_0, green_0, blue_0  in  8 each  even-column pixel.
- red_1, green_1, blue_1  in  8 each  odd-column pixel.
- wr_en  out  1  write strobe, one 6-byte word per cycle.
- wr_addr  out  ADDR_WIDTH  byte address of wr_data[7:0].
- wr_data  out  48  six bytes; byte k is wr_data[8k+7:8k] at wr_addr+k.
- frame_done  out  1  high once the full frame has been written.
- overrun  out  1  sticky error: a beat was dropped.

## Operation
- States: IDLE, HEADER, DATA, DONE.
- A V_sync rising edge is detected against a registered copy of V_sync. It moves the block to HEADER from any state, including mid-DATA (abort and restart). On that edge: clear frame_done, overrun, the header index, row, col and the beat count.
- HEADER: emit 9 words, index h=0..8, wr_addr=6h, holding header bytes 6h..6h+5, little-endian fields:
  - bytes 0-1 'B','M'
  - bytes 2-5 file size 54+W*H*3
  - bytes 6-9 zero
  - bytes 10-13 offset 54
  - bytes 14-17 value 40
  - bytes 18-21 width
  - bytes 22-25 height
  - bytes 26-27 planes 1
  - bytes 28-29 bpp 24
  - bytes 30-33 compression 0
  - bytes 34-37 image size W*H*3
  - bytes 38-53 zero
- After h=8, go to DATA.
- Any H_sync beat while in HEADER is dropped and sets overrun.
- DATA: each H_sync beat writes one word:
  - wr_addr = 54 + WIDTH*3*(HEIGHT-1-row) + 3*col.
  - Bytes 0..5 = red_0, green_0, blue_0, red_1, green_1, blue_1.
  - Then col += 2. When col == WIDTH-2: col <= 0, row += 1.
- When the beat count reaches W*H/2: go to DONE and set frame_done.
- DONE: beats are ignored and set overrun. frame_done holds until reset or the next V_sync rise.
- IDLE: beats are ignored and do not set overrun.
- V_sync falling edge has no effect.
- Address arithmetic uses full-width unsigned values. row and col never exceed HEIGHT-1 and WIDTH-2.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_done=0, overrun=0. State IDLE, counters 0.
- Reset asserted mid-frame: everything returns to reset values immediately. Writing restarts only on a new V_sync rise after rst falls.
- All outputs are registered.
- A beat sampled at edge n produces wr_en/wr_addr/wr_data valid after edge n+1. wr_en is high for exactly one cycle per accepted beat.
- Header: V_sync rise sampled at edge n gives header words on cycles n+1..n+9, wr_en held high continuously. DATA accepts beats from edge n+10.
- frame_done rises in the same cycle as the last pixel word's wr_en.
- V_sync rise coinciding with a beat: the restart wins and the beat is dropped, without setting overrun.
- No back-pressure: the sink accepts a beat every cycle.

## Test plan
- W=4,H=2: reset, then V_sync rise.
  - Required: 9 consecutive header writes.
  - Word0 = 0x0000004E4D42 at addr 0.
  - Word3 (bytes 18-23) = 0x000200000004 at addr 18.
- W=4,H=2: 4 beats after the header, pixel values equal to beat index.
  - Required: addrs 66, 72, 54, 60 in order.
  - frame_done high with the 4th write.
  - overrun=0.
- H_sync beat arriving 3 cycles after the V_sync rise: dropped, overrun=1. Header words remain correct.
- Extra beat after frame_done: no wr_en, overrun=1, frame_done stays 1.
- Second V_sync rise mid-DATA after 2 beats: header restarts at addr 0. The full frame then completes normally with overrun=0.
- rst pulsed mid-DATA: all outputs are 0 in the same cycle. A new beat without a V_sync rise produces no write.

Source files
------------

// File: rtl/bmp_frame_writer.sv
// Rebuilds a 24-bit BMP image from a two-pixel-per-clock RGB stream: 54-byte header
// first, then pixel rows written bottom-up in file order through a 48-bit byte-addressed port.
module bmp_frame_writer #(
    parameter int WIDTH      = 768,
    parameter int HEIGHT     = 512,
    parameter int ADDR_WIDTH = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  V_sync,
    input  logic                  H_sync,
    input  logic [7:0]            red_0,
    input  logic [7:0]            green_0,
    input  logic [7:0]            blue_0,
    input  logic [7:0]            red_1,
    input  logic [7:0]            green_1,
    input  logic [7:0]            blue_1,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [47:0]           wr_data,
    output logic                  frame_done,
    output logic                  overrun
);
    typedef enum logic [1:0] {IDLE, HEADER, DATA, DONE} state_t;

    localparam logic [31:0] IMG_SIZE  = 32'(WIDTH * HEIGHT * 3);
    localparam logic [31:0] FILE_SIZE = IMG_SIZE + 32'd54;
    localparam logic [31:0] W32       = 32'(WIDTH);
    localparam logic [31:0] H32       = 32'(HEIGHT);

    localparam logic [ADDR_WIDTH-1:0] HDR_BYTES = ADDR_WIDTH'(54);
    localparam logic [ADDR_WIDTH-1:0] ROW_BYTES = ADDR_WIDTH'(WIDTH * 3);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_COL  = ADDR_WIDTH'(WIDTH - 2);
    localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = ADDR_WIDTH'(WIDTH * HEIGHT / 2 - 1);

    function automatic logic [7:0] hdr_byte(input int i);
        logic [7:0] b;
        b = 8'h00;
        if (i == 0)                 b = 8'h42;
        else if (i == 1)            b = 8'h4D;
        else if (i >= 2 && i <= 5)  b = 8'(FILE_SIZE >> (8 * (i - 2)));
        else if (i == 10)           b = 8'd54;
        else if (i == 14)           b = 8'd40;
        else if (i >= 18 && i <= 21) b = 8'(W32 >> (8 * (i - 18)));
        else if (i >= 22 && i <= 25) b = 8'(H32 >> (8 * (i - 22)));
        else if (i == 26)           b = 8'd1;
        else if (i == 28)           b = 8'd24;
        else if (i >= 34 && i <= 37) b = 8'(IMG_SIZE >> (8 * (i - 34)));
        return b;
    endfunction

    function automatic logic [47:0] hdr_word(input logic [3:0] h);
        logic [47:0] w;
        w = '0;
        for (int k = 0; k < 6; k++) w[8*k +: 8] = hdr_byte(6 * int'(h) + k);
        return w;
    endfunction

    state_t                  state_q;
    logic                    vsync_q;
    logic [3:0]              hidx_q;
    logic [ADDR_WIDTH-1:0]   row_q, col_q, beat_q;
    logic                    vld_p0, last_p0;
    logic [ADDR_WIDTH-1:0]   pix_addr_p0, pix_addr_d;
    logic [47:0]             pix_data_p0, pix_data_d;
    logic                    rise, accept;

    // A restart edge takes priority over any beat arriving in the same cycle.
    assign rise   = V_sync & ~vsync_q;
    assign accept = H_sync & ~rise & (state_q == DATA);

    always_comb begin
        pix_addr_d = HDR_BYTES + ROW_BYTES * (LAST_ROW - row_q) + ADDR_WIDTH'(3) * col_q;
        pix_data_d = {blue_1, green_1, red_1, blue_0, green_0, red_0};
    end

    // Stage p0: captured pixel word and its file address
    always_ff @(posedge clk) begin
        if (accept) begin
            pix_addr_p0 <= pix_addr_d;
            pix_data_p0 <= pix_data_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            vsync_q    <= 1'b0;
            hidx_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            beat_q     <= '0;
            vld_p0     <= 1'b0;
            last_p0    <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            vsync_q <= V_sync;
            wr_en   <= 1'b0;
            vld_p0  <= accept;
            last_p0 <= accept && (beat_q == LAST_BEAT);
            // Output stage: drain the word captured in p0
            if (vld_p0) begin
                wr_en   <= 1'b1;
                wr_addr <= pix_addr_p0;
                wr_data <= pix_data_p0;
                if (last_p0) frame_done <= 1'b1;
            end
            if (rise) begin
                state_q    <= HEADER;
                hidx_q     <= '0;
                row_q      <= '0;
                col_q      <= '0;
                beat_q     <= '0;
                frame_done <= 1'b0;
                overrun    <= 1'b0;
            end else begin
                case (state_q)
                    HEADER: begin
                        wr_en   <= 1'b1;
                        wr_addr <= ADDR_WIDTH'(6) * ADDR_WIDTH'(hidx_q);
                        wr_data <= hdr_word(hidx_q);
                        hidx_q  <= hidx_q + 4'd1;
                        if (hidx_q == 4'd8) state_q <= DATA;
                        if (H_sync) overrun <= 1'b1;
                    end
                    DATA: begin
                        if (H_sync) begin
                            beat_q <= beat_q + 1'b1;
                            if (beat_q == LAST_BEAT) begin
                                state_q <= DONE;
                                row_q   <= '0;
                                col_q   <= '0;
                            end else if (col_q == LAST_COL) begin
                                col_q <= '0;
                                row_q <= row_q + 1'b1;
                            end else begin
                                col_q <= col_q + ADDR_WIDTH'(2);
                            end
                        end
                    end
                    DONE: begin
                        if (H_sync) overrun <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
